if_id_stage: RTL and testbench
==============================

# if_id_stage

Pipeline register between instruction fetch and decode, with integrated load-use hazard detection and branch flush. Captures the fetched instruction and its PC+4 every cycle. On a load-use hazard it holds its contents and tells the fetch stage to hold the PC. On a taken branch it replaces the wrong-path instruction with a NOP. Also keeps saturating stall and flush counters for performance measurement.

## Interface
- No parameters. Data width is fixed at 32; register specifiers are fixed at 5 bits.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- IF_Instruction  in  32  instruction word from fetch.
- IF_PCPlusFour  in  32  PC+4 from fetch.
- ID_EX_MemRead  in  1  instruction currently in EX is a load.
- ID_EX_Rt  in  5  destination register of that load.
- Branch_Taken  in  1  branch resolved taken in ID this cycle.
- ID_Instruction  out  32  registered instruction to decode.
- ID_PCPlusFour  out  32  registered PC+4 to decode.
- ID_Valid  out  1  ID_Instruction is a real, non-squashed instruction.
- PCWrite  out  1  1 = PC may advance; 0 = hold PC.
- Bubble  out  1  1 = ID/EX must latch zeroed control signals this cycle.
- StallCount  out  32  number of hazard-stall cycles, saturating.
- FlushCount  out  32  number of branch flushes, saturating.

## Operation
- Reset (Reset=0, asynchronous) sets:
  - ID_Instruction=32'h0000_0000 (NOP, sll $0,$0,0), ID_PCPlusFour=0, ID_Valid=0.
  - StallCount=0, FlushCount=0.
- Hazard is combinational. Hazard = ID_Valid & ID_EX_MemRead & (ID_EX_Rt≠0) & (RsMatch | RtMatch).
  - RsMatch: ID_EX_Rt==ID_Instruction[25:21].
  - RtMatch: ID_EX_Rt==ID_Instruction[20:16], and opcode ID_Instruction[31:26] ∈ {0x00, 0x04, 0x05, 0x1C, 0x28, 0x29, 0x2B}. These are the opcodes that read rt.
- PCWrite = ~Hazard. Bubble = Hazard.
- FlushReq = Branch_Taken & ID_Valid & ~Hazard.
- Update at each rising edge, in priority order:
  - Hazard: hold ID_Instruction, ID_PCPlusFour and ID_Valid. StallCount+1.
  - FlushReq: ID_Instruction←0, ID_Valid←0. ID_PCPlusFour←IF_PCPlusFour. FlushCount+1.
  - Otherwise: ID_Instruction←IF_Instruction, ID_PCPlusFour←IF_PCPlusFour, ID_Valid←1.
- Hazard beats branch. A branch that depends on a load is not resolved correctly in ID, so Branch_Taken is ignored while Hazard=1. The branch re-evaluates on the following cycle.
- Branch_Taken is ignored when ID_Valid=0, so a squashed slot can never cause a second flush.
- Both counters saturate at 32'hFFFF_FFFF and never wrap.
- A NOP whose rs field is $0 never hazards, because of the Rt≠0 term.

## Timing
- Latency IF→ID: 1 cycle.
- Hazard, PCWrite and Bubble are combinational from registered state plus the ID_EX inputs, and are valid within the same cycle. There is no path from IF_* inputs to them.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has moved to MEM, ID_EX_MemRead reflects the bubble (0), and Hazard drops.
- Flush costs exactly 1 slot: the instruction fetched in the same cycle as the branch becomes a NOP.
- Reset mid-stall or mid-flush: outputs return to reset values immediately. PCWrite=1 while in reset, because ID_Valid=0.
- The first rising edge after reset release captures IF_* with ID_Valid←1.

## Structure
- Shared package `pipeline_pkg` holds:
  - NOP_INSTR=32'h0.
  - Opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SPECIAL2, OP_SB, OP_SH, OP_SW.
  - Field-position constants for rs, rt and opcode.
- Sub-module `load_use_detector` (combinational) computes Hazard from ID_Instruction, ID_Valid, ID_EX_MemRead and ID_EX_Rt. It is reused later by the forwarding/hazard unit.
- Top level holds the pipeline registers, the priority update logic and the two saturating counters.

## Test plan
- Reset then release, with IF_Instruction=32'h2008_0005 and IF_PCPlusFour=4:
  - After reset: ID_Valid=0, PCWrite=1, counters 0.
  - After 1 edge: ID_Instruction=32'h2008_0005, ID_PCPlusFour=4, ID_Valid=1.
- Load-use, ID holds add $t2,$t0,$t1 (32'h0109_5020) with ID_EX_MemRead=1 and ID_EX_Rt=9:
  - PCWrite=0 and Bubble=1 the same cycle.
  - Registers held 1 edge; StallCount=1.
  - Next cycle with MemRead=0: register advances.
- Store rt dependence: ID holds sw $t1,0($s0) with ID_EX_Rt=9 → Hazard=1.
  - Same encoding with opcode changed to lw (0x23) → Hazard=0.
- Branch_Taken=1 with ID_Valid=1 and no hazard → next ID_Instruction=0, ID_Valid=0, FlushCount=1.
  - Branch_Taken held high one more cycle → no second flush.
- Branch_Taken=1 together with a Hazard → hold, FlushCount unchanged, StallCount+1.
- Counter saturation: force StallCount to 32'hFFFF_FFFE, stall 3 cycles → StallCount=32'hFFFF_FFFF.
  - Assert Reset mid-stall → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared constants and helpers for the MIPS-style pipeline stages.
//   - NOP_INSTR          : canonical NOP (sll $0,$0,0)
//   - OP_*               : opcodes whose rt field is a source operand
//   - *_MSB / *_LSB      : instruction field positions for opcode, rs and rt
//   - reads_rt()         : true when an opcode consumes rt as a source
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 6;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [OP_W-1:0]   opcode_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  localparam opcode_t OP_RTYPE    = 6'h00;
  localparam opcode_t OP_BEQ      = 6'h04;
  localparam opcode_t OP_BNE      = 6'h05;
  localparam opcode_t OP_SPECIAL2 = 6'h1C;
  localparam opcode_t OP_SB       = 6'h28;
  localparam opcode_t OP_SH       = 6'h29;
  localparam opcode_t OP_SW       = 6'h2B;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  // Loads and immediates write rt rather than read it, so they are excluded.
  function automatic logic reads_rt(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SPECIAL2) || (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW);
  endfunction

endpackage : pipeline_pkg

// File: rtl/load_use_detector.sv
// -----------------------------------------------------------------------------
// load_use_detector
//   Purely combinational load-use hazard check for the instruction sitting in
//   ID against a load currently in EX.
//   Ports:
//     ID_Instruction  in  32  instruction held in the IF/ID register
//     ID_Valid        in  1   that instruction is real (not squashed/reset)
//     ID_EX_MemRead   in  1   instruction in EX is a load
//     ID_EX_Rt        in  5   destination register of that load
//     Hazard          out 1   ID must stall one cycle
// -----------------------------------------------------------------------------
module load_use_detector
  import pipeline_pkg::*;
(
  input  logic [31:0] ID_Instruction,
  input  logic        ID_Valid,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  output logic        Hazard
);

  opcode_t  opcode;
  reg_idx_t rs_field;
  reg_idx_t rt_field;
  logic     rs_match;
  logic     rt_match;

  assign opcode   = ID_Instruction[OP_MSB:OP_LSB];
  assign rs_field = ID_Instruction[RS_MSB:RS_LSB];
  assign rt_field = ID_Instruction[RT_MSB:RT_LSB];

  assign rs_match = (ID_EX_Rt == rs_field);
  assign rt_match = (ID_EX_Rt == rt_field) && reads_rt(opcode);

  // $0 is hardwired to zero, so a load targeting it can never create a
  // dependence; this also keeps the reset NOP from stalling.
  assign Hazard = ID_Valid && ID_EX_MemRead && (ID_EX_Rt != '0) &&
                  (rs_match || rt_match);

endmodule : load_use_detector

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   IF/ID pipeline register with load-use stall and taken-branch squash, plus
//   saturating stall/flush performance counters.
//   Ports:
//     Clock, Reset           in      rising-edge clock, async active-low reset
//     IF_Instruction         in  32  instruction word from fetch
//     IF_PCPlusFour          in  32  PC+4 from fetch
//     ID_EX_MemRead          in  1   instruction in EX is a load
//     ID_EX_Rt               in  5   destination register of that load
//     Branch_Taken           in  1   branch in ID resolved taken this cycle
//     ID_Instruction         out 32  registered instruction to decode
//     ID_PCPlusFour          out 32  registered PC+4 to decode
//     ID_Valid               out 1   ID_Instruction is real, not squashed
//     PCWrite                out 1   PC may advance (0 = hold)
//     Bubble                 out 1   ID/EX must latch zeroed control
//     StallCount, FlushCount out 32  saturating performance counters
// -----------------------------------------------------------------------------
module if_id_stage
  import pipeline_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IF_Instruction,
  input  logic [31:0] IF_PCPlusFour,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        Branch_Taken,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCPlusFour,
  output logic        ID_Valid,
  output logic        PCWrite,
  output logic        Bubble,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  localparam word_t CNT_MAX = '1;

  word_t instr_q,     instr_d;
  word_t pc4_q,       pc4_d;
  logic  valid_q,     valid_d;
  word_t stall_cnt_q, stall_cnt_d;
  word_t flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic flush_req;

  load_use_detector u_load_use_detector (
    .ID_Instruction (instr_q),
    .ID_Valid       (valid_q),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_Rt       (ID_EX_Rt),
    .Hazard         (hazard)
  );

  // A branch depending on a stalled load is not yet resolved correctly, and a
  // squashed slot must never trigger a second flush.
  assign flush_req = Branch_Taken && valid_q && !hazard;

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (hazard) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 32'd1;
    end else if (flush_req) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      pc4_d   = IF_PCPlusFour;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      instr_d = IF_Instruction;
      pc4_d   = IF_PCPlusFour;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      instr_q     <= NOP_INSTR;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_Instruction = instr_q;
  assign ID_PCPlusFour  = pc4_q;
  assign ID_Valid       = valid_q;
  assign PCWrite        = !hazard;
  assign Bubble         = hazard;
  assign StallCount     = stall_cnt_q;
  assign FlushCount     = flush_cnt_q;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model of the IF/ID register kept in this bench.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCPlusFour;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rt;
  logic        Branch_Taken;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCPlusFour;
  logic        ID_Valid;
  logic        PCWrite;
  logic        Bubble;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  always #5 Clock = ~Clock;

  if_id_stage dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .IF_Instruction (IF_Instruction),
    .IF_PCPlusFour  (IF_PCPlusFour),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_Rt       (ID_EX_Rt),
    .Branch_Taken   (Branch_Taken),
    .ID_Instruction (ID_Instruction),
    .ID_PCPlusFour  (ID_PCPlusFour),
    .ID_Valid       (ID_Valid),
    .PCWrite        (PCWrite),
    .Bubble         (Bubble),
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard();
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    op = m_instr[31:26];
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    uses_rt = op inside {6'h00, 6'h04, 6'h05, 6'h1C, 6'h28, 6'h29, 6'h2B};
    return m_valid && ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
           ((ID_EX_Rt == rs) || (uses_rt && (ID_EX_Rt == rt)));
  endfunction

  function automatic void model_reset();
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_stall = 32'h0;
    m_flush = 32'h0;
  endfunction

  // Applies one rising edge worth of the stage's rules to the model.
  function automatic void model_edge();
    if (model_hazard()) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end else if (Branch_Taken && m_valid) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_pc    = IF_PCPlusFour;
      if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    end else begin
      m_instr = IF_Instruction;
      m_pc    = IF_PCPlusFour;
      m_valid = 1'b1;
    end
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".instr"}, ID_Instruction, m_instr);
    check({tag, ".pc4"},   ID_PCPlusFour,  m_pc);
    check({tag, ".valid"}, ID_Valid,       m_valid);
    check({tag, ".stall"}, StallCount,     m_stall);
    check({tag, ".flush"}, FlushCount,     m_flush);
  endtask

  // Inputs are expected to be stable already; returns 1 time unit after the
  // rising edge so the caller can drive the next step.
  task automatic cycle(input string tag);
    logic hz;
    @(negedge Clock);
    hz = model_hazard();
    check({tag, ".pcwrite"}, PCWrite, !hz);
    check({tag, ".bubble"},  Bubble,  hz);
    @(posedge Clock);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic memread, input logic [4:0] rt,
                       input logic br);
    IF_Instruction = instr;
    IF_PCPlusFour  = pc4;
    ID_EX_MemRead  = memread;
    ID_EX_Rt       = rt;
    Branch_Taken   = br;
  endtask

  initial begin
    logic [5:0] ops [9];
    ops = '{6'h00, 6'h04, 6'h05, 6'h1C, 6'h28, 6'h29, 6'h2B, 6'h23, 6'h08};

    // ---- reset ----
    Reset = 1'b0;
    drive(32'h2008_0005, 32'd4, 1'b0, 5'd0, 1'b0);
    model_reset();
    #12;
    check("rst.valid",   ID_Valid,       1'b0);
    check("rst.pcwrite", PCWrite,        1'b1);
    check("rst.stall",   StallCount,     32'h0);
    check("rst.flush",   FlushCount,     32'h0);
    check("rst.instr",   ID_Instruction, 32'h0);
    @(negedge Clock);
    Reset = 1'b1;

    // ---- first capture ----
    cycle("cap");
    check("cap.instr_const", ID_Instruction, 32'h2008_0005);
    check("cap.pc_const",    ID_PCPlusFour,  32'd4);

    // ---- load-use on rt of an R-type ----
    drive(32'h0109_5020, 32'd8, 1'b0, 5'd0, 1'b0);
    cycle("add_load");
    drive(32'hDEAD_BEEF, 32'd12, 1'b1, 5'd9, 1'b0);
    #1;
    check("lu.pcwrite_const", PCWrite, 1'b0);
    check("lu.bubble_const",  Bubble,  1'b1);
    cycle("lu_stall");
    check("lu.held_const",  ID_Instruction, 32'h0109_5020);
    check("lu.stall_const", StallCount,     32'd1);
    ID_EX_MemRead = 1'b0;
    cycle("lu_release");
    check("lu.adv_const", ID_Instruction, 32'hDEAD_BEEF);

    // ---- store reads rt, load does not ----
    drive(32'hAE09_0000, 32'd16, 1'b0, 5'd0, 1'b0);
    cycle("sw_load");
    drive(32'h8E09_0000, 32'd20, 1'b1, 5'd9, 1'b0);
    #1;
    check("sw.hazard_const", Bubble, 1'b1);
    cycle("sw_stall");
    ID_EX_MemRead = 1'b0;
    cycle("lw_load");
    drive(32'h0000_0000, 32'd24, 1'b1, 5'd9, 1'b0);
    #1;
    check("lw.nohazard_const", Bubble, 1'b0);
    cycle("lw_pass");

    // ---- branch flush, then branch held high ----
    drive(32'h1111_1111, 32'd28, 1'b0, 5'd0, 1'b0);
    cycle("pre_br");
    drive(32'h2222_2222, 32'd32, 1'b0, 5'd0, 1'b1);
    cycle("br_flush");
    check("br.instr_const", ID_Instruction, 32'h0);
    check("br.valid_const", ID_Valid,       1'b0);
    check("br.flush_const", FlushCount,     32'd1);
    drive(32'h0109_5020, 32'd36, 1'b0, 5'd0, 1'b1);
    cycle("br_hold");
    check("br2.flush_const", FlushCount, 32'd1);
    check("br2.valid_const", ID_Valid,   1'b1);

    // ---- branch together with hazard ----
    drive(32'h3333_3333, 32'd40, 1'b1, 5'd8, 1'b1);
    cycle("br_hz");
    check("brhz.flush_const", FlushCount,     32'd1);
    check("brhz.instr_const", ID_Instruction, 32'h0109_5020);

    // ---- stall counter saturation, then async reset mid-stall ----
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle("sat");
    check("sat.const", StallCount, 32'hFFFF_FFFF);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check_regs("rst_mid");
    check("rst_mid.pcwrite", PCWrite, 1'b1);
    check("rst_mid.bubble",  Bubble,  1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    drive(32'h2008_0005, 32'd4, 1'b0, 5'd0, 1'b0);
    cycle("post_rst");

    // ---- randomized traffic with small register fields to provoke hazards ----
    for (int n = 0; n < 300; n++) begin
      logic [31:0] instr;
      instr = {ops[$urandom_range(8)], 5'($urandom_range(3)),
               5'($urandom_range(3)), 16'($urandom)};
      drive(instr, $urandom, ($urandom_range(1) == 1), 5'($urandom_range(3)),
            ($urandom_range(3) == 0));
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_if_id_stage
